// File: rtl/msf_pulse_decoder.sv
// MSF carrier pulse decoder: times each second's carrier-off pulse and classifies it as bits A/B, minute marker or error.
// Define MSF_GLITCH_FILTER_EN to derive the carrier level from a 3-tap majority of tick samples.
module msf_pulse_decoder #(
  parameter int unsigned T_CHECK   = 50,
  parameter int unsigned T_A       = 150,
  parameter int unsigned T_B       = 250,
  parameter int unsigned T_MIN     = 450,
  parameter int unsigned T_DONE    = 600,
  parameter int unsigned T_REARM   = 900,
  parameter int unsigned T_TIMEOUT = 1100
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic msf_i,
  output logic second_o,
  output logic bit_valid_o,
  output logic bit_a_o,
  output logic bit_b_o,
  output logic minute_o,
  output logic error_o
);

  localparam int unsigned T_W = 11;
  localparam logic [T_W-1:0] T_SAT = '1;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    MEASURE = 2'd1,
    GAP     = 2'd2,
    ARMED   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [T_W-1:0] t_q, t_d;
  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic           c_q, c_d;
  logic           a_q, a_d;
  logic           b_q, b_d;
  logic           m_q, m_d;
  logic           second_q, second_d;
  logic           bit_valid_q, bit_valid_d;
  logic           bit_a_q, bit_a_d;
  logic           bit_b_q, bit_b_d;
  logic           minute_q, minute_d;
  logic           error_q, error_d;
  logic           c_new;
  logic           fall;
  logic [T_W-1:0] t_inc;

`ifdef MSF_GLITCH_FILTER_EN
  logic h1_q, h1_d;
  logic h2_q, h2_d;

  // Majority of the current and two previous tick samples; delays edges by one tick.
  assign c_new = (sync2_q & h1_q) | (sync2_q & h2_q) | (h1_q & h2_q);
`else
  assign c_new = sync2_q;
`endif

  assign fall  = c_q & ~c_new;
  assign t_inc = (t_q == T_SAT) ? t_q : t_q + 11'd1;

  always_comb begin
    sync1_d     = msf_i;
    sync2_d     = sync1_q;
    state_d     = state_q;
    t_d         = t_q;
    c_d         = c_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    bit_a_d     = bit_a_q;
    bit_b_d     = bit_b_q;
    second_d    = 1'b0;
    bit_valid_d = 1'b0;
    minute_d    = 1'b0;
    error_d     = 1'b0;
`ifdef MSF_GLITCH_FILTER_EN
    h1_d        = h1_q;
    h2_d        = h2_q;
`endif

    if (tick_i) begin
      c_d = c_new;
      t_d = t_inc;
`ifdef MSF_GLITCH_FILTER_EN
      h1_d = sync2_q;
      h2_d = h1_q;
`endif
      case (state_q)
        HUNT: begin
          if (fall) begin
            state_d  = MEASURE;
            t_d      = '0;
            second_d = 1'b1;
          end
        end

        // Edges are ignored here so the second pulse of an A0B1 symbol is not a new second.
        MEASURE: begin
          if (t_inc == T_W'(T_A))   a_d = ~c_new;
          if (t_inc == T_W'(T_B))   b_d = ~c_new;
          if (t_inc == T_W'(T_MIN)) m_d = ~c_new;
          if (t_inc == T_W'(T_CHECK) && c_new) begin
            error_d = 1'b1;
            state_d = HUNT;
          end else if (t_inc == T_W'(T_DONE)) begin
            if (!c_new) begin
              error_d = 1'b1;
              state_d = HUNT;
            end else if (m_q && a_q && b_q) begin
              minute_d = 1'b1;
              state_d  = GAP;
            end else if (m_q) begin
              error_d = 1'b1;
              state_d = HUNT;
            end else begin
              bit_valid_d = 1'b1;
              bit_a_d     = a_q;
              bit_b_d     = b_q;
              state_d     = GAP;
            end
          end
        end

        GAP: begin
          if (t_inc >= T_W'(T_REARM)) begin
            if (fall) begin
              state_d  = MEASURE;
              t_d      = '0;
              second_d = 1'b1;
            end else begin
              state_d = ARMED;
            end
          end else if (fall) begin
            error_d = 1'b1;
            state_d = HUNT;
          end
        end

        ARMED: begin
          if (fall) begin
            state_d  = MEASURE;
            t_d      = '0;
            second_d = 1'b1;
          end else if (t_inc >= T_W'(T_TIMEOUT)) begin
            error_d = 1'b1;
            state_d = HUNT;
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= HUNT;
      t_q         <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      c_q         <= 1'b1;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      m_q         <= 1'b0;
      bit_a_q     <= 1'b0;
      bit_b_q     <= 1'b0;
      second_q    <= 1'b0;
      bit_valid_q <= 1'b0;
      minute_q    <= 1'b0;
      error_q     <= 1'b0;
`ifdef MSF_GLITCH_FILTER_EN
      h1_q        <= 1'b1;
      h2_q        <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      c_q         <= c_d;
      a_q         <= a_d;
      b_q         <= b_d;
      m_q         <= m_d;
      bit_a_q     <= bit_a_d;
      bit_b_q     <= bit_b_d;
      second_q    <= second_d;
      bit_valid_q <= bit_valid_d;
      minute_q    <= minute_d;
      error_q     <= error_d;
`ifdef MSF_GLITCH_FILTER_EN
      h1_q        <= h1_d;
      h2_q        <= h2_d;
`endif
    end
  end

  assign second_o    = second_q;
  assign bit_valid_o = bit_valid_q;
  assign bit_a_o     = bit_a_q;
  assign bit_b_o     = bit_b_q;
  assign minute_o    = minute_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_msf_pulse_decoder.sv
// Directed bench for msf_pulse_decoder: carrier patterns driven in ticks, pulses timed against the second_o tick.
module tb_msf_pulse_decoder;

  logic clk = 1'b0;
  logic rst_i, tick_i, msf_i;
  logic second_o, bit_valid_o, bit_a_o, bit_b_o, minute_o, error_o;

  int n_chk = 0, n_fail = 0, tick_n = 0;
  int n_sec = 0, n_val = 0, n_min = 0, n_err = 0, n_ovl = 0;
  int sec_tk = 0, val_tk = 0, min_tk = 0, err_tk = 0;
  int val_a = 0, val_b = 0;
  int b_sec, b_val, b_min, b_err, s_first;

  msf_pulse_decoder dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .tick_i     (tick_i),
    .msf_i      (msf_i),
    .second_o   (second_o),
    .bit_valid_o(bit_valid_o),
    .bit_a_o    (bit_a_o),
    .bit_b_o    (bit_b_o),
    .minute_o   (minute_o),
    .error_o    (error_o)
  );

  always #5 clk = ~clk;

  // Pulses are sampled on the falling edge and stamped with the tick that caused them.
  always @(negedge clk) begin
    if (second_o)    begin n_sec++; sec_tk = tick_n; end
    if (bit_valid_o) begin n_val++; val_tk = tick_n; val_a = int'(bit_a_o); val_b = int'(bit_b_o); end
    if (minute_o)    begin n_min++; min_tk = tick_n; end
    if (error_o)     begin n_err++; err_tk = tick_n; end
    if (int'(second_o) + int'(bit_valid_o) + int'(minute_o) + int'(error_o) > 1) n_ovl++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input logic lvl, input int n);
    msf_i = lvl;
    for (int i = 0; i < n; i++) begin
      repeat (2) @(negedge clk);
      tick_n++;
      tick_i = 1'b1;
      @(negedge clk);
      tick_i = 1'b0;
    end
  endtask

  task automatic mark();
    b_sec = n_sec; b_val = n_val; b_min = n_min; b_err = n_err;
  endtask

  initial begin
    rst_i  = 1'b1;
    tick_i = 1'b1;
    msf_i  = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_second", int'(second_o), 0);
    check("rst_valid",  int'(bit_valid_o), 0);
    check("rst_bit_a",  int'(bit_a_o), 0);
    check("rst_bit_b",  int'(bit_b_o), 0);
    check("rst_minute", int'(minute_o), 0);
    check("rst_error",  int'(error_o), 0);
    rst_i  = 1'b0;
    tick_i = 1'b0;

    // Idle with carrier present
    mark();
    run(1'b1, 2000);
    check("idle_pulses", (n_sec - b_sec) + (n_val - b_val) + (n_min - b_min) + (n_err - b_err), 0);

    // Reset in the middle of a second discards it
    mark();
    run(1'b0, 100);
    @(negedge clk);
    rst_i = 1'b1; tick_i = 1'b1; msf_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0; tick_i = 1'b0;
    run(1'b1, 1200);
    check("midrst_sec",   n_sec - b_sec, 1);
    check("midrst_valid", n_val - b_val, 0);
    check("midrst_error", n_err - b_err, 0);
    check("midrst_min",   n_min - b_min, 0);

    // Three 100 ms seconds: A=0 B=0
    mark();
    for (int s = 0; s < 3; s++) begin
      run(1'b0, 100);
      run(1'b1, 900);
    end
    check("a0b0_sec",   n_sec - b_sec, 3);
    check("a0b0_valid", n_val - b_val, 3);
    check("a0b0_error", n_err - b_err, 0);
    check("a0b0_a",     val_a, 0);
    check("a0b0_b",     val_b, 0);
    check("a0b0_lat",   val_tk - sec_tk, 600);

    // 300 ms: A=1 B=1
    mark();
    run(1'b0, 300);
    run(1'b1, 700);
    check("a1b1_valid", n_val - b_val, 1);
    check("a1b1_a",     val_a, 1);
    check("a1b1_b",     val_b, 1);
    check("a1b1_lat",   val_tk - sec_tk, 600);

    // A0B1 double pulse
    mark();
    run(1'b0, 100);
    run(1'b1, 100);
    run(1'b0, 100);
    run(1'b1, 700);
    check("a0b1_sec",   n_sec - b_sec, 1);
    check("a0b1_valid", n_val - b_val, 1);
    check("a0b1_error", n_err - b_err, 0);
    check("a0b1_a",     val_a, 0);
    check("a0b1_b",     val_b, 1);

    // 500 ms: minute marker
    mark();
    run(1'b0, 500);
    run(1'b1, 500);
    check("min_count", n_min - b_min, 1);
    check("min_valid", n_val - b_val, 0);
    check("min_error", n_err - b_err, 0);
    check("min_lat",   min_tk - sec_tk, 600);

    // 700 ms: carrier still off at the decision point
    mark();
    run(1'b0, 700);
    run(1'b1, 400);
    check("long_error", n_err - b_err, 1);
    check("long_valid", n_val - b_val, 0);
    check("long_min",   n_min - b_min, 0);
    check("long_lat",   err_tk - sec_tk, 600);

`ifdef MSF_GLITCH_FILTER_EN
    mark();
    run(1'b0, 1);
    run(1'b1, 100);
    check("spike_sec",   n_sec - b_sec, 0);
    check("spike_error", n_err - b_err, 0);
`else
    mark();
    run(1'b0, 20);
    run(1'b1, 100);
    check("glitch_sec",   n_sec - b_sec, 1);
    check("glitch_error", n_err - b_err, 1);
    check("glitch_lat",   err_tk - sec_tk, 50);
`endif

    // Missing next second: timeout, then HUNT stays silent
    mark();
    run(1'b0, 100);
    run(1'b1, 1300);
    check("tmo_valid", n_val - b_val, 1);
    check("tmo_error", n_err - b_err, 1);
    check("tmo_lat",   err_tk - sec_tk, 1100);

    // Early edge inside the gap
    mark();
    run(1'b0, 100);
    s_first = sec_tk;
    run(1'b1, 600);
    run(1'b0, 100);
    run(1'b1, 100);
    run(1'b0, 100);
    run(1'b1, 900);
    check("gap_error",  n_err - b_err, 1);
    check("gap_lat",    err_tk - s_first, 700);
    check("gap_sec",    n_sec - b_sec, 2);
    check("gap_valid",  n_val - b_val, 2);
    check("gap_newsec", sec_tk - s_first, 900);
    check("gap_b",      val_b, 0);
    check("gap_lat2",   val_tk - sec_tk, 600);

    check("overlap", n_ovl, 0);
    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule
